// File: rtl/uart_loader.sv
// Serial bootloader sequencer: parses SYNC/ADDR/LEN/DATA/CHK frames from a byte stream and issues 32-bit memory writes.
// Latency: 4th data byte handshake -> mem_valid next cycle; CHK byte handshake -> done/error next cycle.
// Backpressure: rx_ready drops while a write waits for mem_ready and on the done/error cycle; no wait limit on mem_ready.
module uart_loader #(
    parameter int          ADDR_W  = 32,
    parameter logic [7:0]  SYNC    = 8'hA5,
    parameter int          TIMEOUT = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              cpu_rst
);

    localparam int GW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_LEN,
        S_DATA,
        S_WRITE,
        S_CHK
    } state_t;

    state_t            r_state;
    logic              r_rx_ready;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_mem_valid;
    logic              r_busy;
    logic              r_done;
    logic              r_error;
    logic              r_cpu_rst;
    logic [31:0]       r_word;     // byte shifter shared by ADDR, LEN and DATA fields
    logic [1:0]        r_bcnt;
    logic [15:0]       r_wcnt;
    logic [7:0]        r_csum;
    logic [GW-1:0]     r_gap;

    logic              w_acc;
    logic [31:0]       w_word_nxt;
    logic [ADDR_W-1:0] w_addr_in;
    logic              w_rx_state;
    logic              w_gap_exp;

    // Bytes arrive LSB first, so each new byte enters at the top of the shifter.
    assign w_acc      = rx_valid & r_rx_ready;
    assign w_word_nxt = {rx_data, r_word[31:8]};
    assign w_addr_in  = ADDR_W'(w_word_nxt);
    assign w_rx_state = (r_state == S_ADDR) || (r_state == S_LEN) ||
                        (r_state == S_DATA) || (r_state == S_CHK);
    assign w_gap_exp  = (r_gap == GW'(TIMEOUT - 1));

    // Frame sequencer: parsing, write issue, checksum verdict and inter-byte timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_rx_ready  <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_mem_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_cpu_rst   <= 1'b0;
            r_word      <= '0;
            r_bcnt      <= '0;
            r_wcnt      <= '0;
            r_csum      <= '0;
            r_gap       <= '0;
        end else begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_rx_ready <= 1'b1;
                    if (w_acc && rx_data == SYNC) begin
                        r_state   <= S_ADDR;
                        r_bcnt    <= '0;
                        r_csum    <= '0;
                        r_gap     <= '0;
                        r_cpu_rst <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end
                S_ADDR: begin
                    if (w_acc) begin
                        r_word <= w_word_nxt;
                        r_gap  <= '0;
                        r_bcnt <= r_bcnt + 2'd1;
                        if (r_bcnt == 2'd3) begin
                            r_addr  <= w_addr_in & ~ADDR_W'(3);
                            r_bcnt  <= '0;
                            r_state <= S_LEN;
                        end
                    end
                end
                S_LEN: begin
                    if (w_acc) begin
                        r_word <= w_word_nxt;
                        r_gap  <= '0;
                        r_bcnt <= r_bcnt + 2'd1;
                        if (r_bcnt == 2'd1) begin
                            // Two bytes shifted in land in the top half of the shifter.
                            r_bcnt <= '0;
                            r_wcnt <= w_word_nxt[31:16];
                            r_state <= (w_word_nxt[31:16] == 16'd0) ? S_CHK : S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (w_acc) begin
                        r_word <= w_word_nxt;
                        r_csum <= r_csum ^ rx_data;
                        r_gap  <= '0;
                        r_bcnt <= r_bcnt + 2'd1;
                        if (r_bcnt == 2'd3) begin
                            r_bcnt      <= '0;
                            r_wdata     <= w_word_nxt;
                            r_mem_valid <= 1'b1;
                            r_rx_ready  <= 1'b0;
                            r_state     <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    if (mem_ready) begin
                        r_mem_valid <= 1'b0;
                        r_addr      <= r_addr + ADDR_W'(4);
                        r_wcnt      <= r_wcnt - 16'd1;
                        r_rx_ready  <= 1'b1;
                        r_gap       <= '0;
                        r_state     <= (r_wcnt == 16'd1) ? S_CHK : S_DATA;
                    end
                end
                S_CHK: begin
                    if (w_acc) begin
                        r_done     <= (rx_data == r_csum);
                        r_error    <= (rx_data != r_csum);
                        r_cpu_rst  <= 1'b0;
                        r_busy     <= 1'b0;
                        r_rx_ready <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // Silence inside a frame: abort, dropping any partial word.
            if (w_rx_state && !w_acc) begin
                if (w_gap_exp) begin
                    r_error    <= 1'b1;
                    r_cpu_rst  <= 1'b0;
                    r_busy     <= 1'b0;
                    r_rx_ready <= 1'b0;
                    r_bcnt     <= '0;
                    r_state    <= S_IDLE;
                end else begin
                    r_gap <= r_gap + GW'(1);
                end
            end
        end
    end

    assign rx_ready  = r_rx_ready;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_valid = r_mem_valid;
    assign busy      = r_busy;
    assign done      = r_done;
    assign error     = r_error;
    assign cpu_rst   = r_cpu_rst;

endmodule
